memory_responder: RTL

MEMORY_RESPONDER -- requirements
Module: memory_responder

---
 rtl/memory_responder_pkg.sv | 14 +
 rtl/memory_array.sv | 33 +++
 rtl/memory_responder.sv | 148 ++++++++++++++
 3 files changed

// File: rtl/memory_responder_pkg.sv
// Shared types and widths for the memory responder slice.
package memory_responder_pkg;

   localparam int WORD_WIDTH     = 64;
   localparam int ADDRESS_WIDTH  = 64;
   localparam int BYTES_PER_WORD = 8;

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      WAIT    = 2'd1,
      RESPOND = 2'd2
   } state_t;

endpackage

// File: rtl/memory_array.sv
// Word storage with per-byte write enables: writes land on the rising edge,
// reads are combinational. Contents are deliberately not reset.
module memory_array
   import memory_responder_pkg::*;
#(
   parameter int DEPTH       = 256,
   parameter int INDEX_WIDTH = $clog2(DEPTH)
) (
   input  logic                      clock,
   input  logic                      write_enable,
   input  logic [INDEX_WIDTH-1:0]    write_index,
   input  logic [WORD_WIDTH-1:0]     write_data,
   input  logic [BYTES_PER_WORD-1:0] byte_enable,
   input  logic [INDEX_WIDTH-1:0]    read_index,
   output logic [WORD_WIDTH-1:0]     read_data
);

   logic [WORD_WIDTH-1:0] storage [DEPTH];

   // Commit each enabled byte lane of the addressed word.
   always_ff @(posedge clock) begin
      if (write_enable) begin
         for (int i = 0; i < BYTES_PER_WORD; i++) begin
            if (byte_enable[i]) begin
               storage[write_index][8*i +: 8] <= write_data[8*i +: 8];
            end
         end
      end
   end

   assign read_data = storage[read_index];

endmodule

// File: rtl/memory_responder.sv
// Single-outstanding-request memory responder with a fixed number of wait
// states. Define MEMORY_RESPONDER_BYTE_MASK_EN to add req_byte_mask and
// per-byte stores; otherwise every store writes the whole word.
module memory_responder
   import memory_responder_pkg::*;
#(
   parameter int DEPTH       = 256,
   parameter int WAIT_CYCLES = 2
) (
   input  logic                      clock,
   input  logic                      reset,
   input  logic                      req_valid,
   output logic                      req_ready,
   input  logic                      req_write,
   input  logic [ADDRESS_WIDTH-1:0]  req_address,
   input  logic [WORD_WIDTH-1:0]     req_data,
`ifdef MEMORY_RESPONDER_BYTE_MASK_EN
   input  logic [BYTES_PER_WORD-1:0] req_byte_mask,
`endif
   output logic                      resp_valid,
   input  logic                      resp_ready,
   output logic [WORD_WIDTH-1:0]     resp_data,
   output logic                      resp_error
);

   localparam int INDEX_WIDTH = $clog2(DEPTH);
   localparam logic [3:0] WAIT_INIT = (WAIT_CYCLES > 0) ? 4'(WAIT_CYCLES - 1) : 4'd0;

   state_t state, next_state;
   logic [3:0] counter;

   logic                      cap_write;
   logic [ADDRESS_WIDTH-1:0]  cap_address;
   logic [WORD_WIDTH-1:0]     cap_data;
`ifdef MEMORY_RESPONDER_BYTE_MASK_EN
   logic [BYTES_PER_WORD-1:0] cap_mask;
`endif

   logic                      cur_write;
   logic [ADDRESS_WIDTH-1:0]  cur_address;
   logic [WORD_WIDTH-1:0]     cur_data;
   logic [BYTES_PER_WORD-1:0] cur_mask;
   logic                      accept;
   logic                      enter_respond;
   logic                      request_error;
   logic                      write_enable;
   logic [WORD_WIDTH-1:0]     read_data;

   // With zero wait states the commit shares the accept edge, so the live
   // request is used in IDLE and the captured copy everywhere else.
   always_comb begin
      cur_write   = (state == IDLE) ? req_write   : cap_write;
      cur_address = (state == IDLE) ? req_address : cap_address;
      cur_data    = (state == IDLE) ? req_data    : cap_data;
`ifdef MEMORY_RESPONDER_BYTE_MASK_EN
      cur_mask    = (state == IDLE) ? req_byte_mask : cap_mask;
`else
      cur_mask    = '1;
`endif
   end

   assign accept        = (state == IDLE) && req_valid;
   assign enter_respond = (accept && (WAIT_CYCLES == 0)) || ((state == WAIT) && (counter == 4'd0));
   assign request_error = (|cur_address[2:0]) || (|(cur_address >> (INDEX_WIDTH + 3)));
   assign write_enable  = enter_respond && cur_write && !request_error;

   memory_array #(
      .DEPTH       (DEPTH),
      .INDEX_WIDTH (INDEX_WIDTH)
   ) u_memory_array (
      .clock        (clock),
      .write_enable (write_enable),
      .write_index  (cur_address[3 +: INDEX_WIDTH]),
      .write_data   (cur_data),
      .byte_enable  (cur_mask),
      .read_index   (cur_address[3 +: INDEX_WIDTH]),
      .read_data    (read_data)
   );

   // State register; reset drops any pending request immediately.
   always_ff @(posedge clock or posedge reset) begin
      if (reset) state <= IDLE;
      else       state <= next_state;
   end

   // Next-state: one request at a time, wait states, then hold until taken.
   always_comb begin
      next_state = state;
      case (state)
         IDLE: begin
            if (req_valid) begin
               if (WAIT_CYCLES > 0) next_state = WAIT;
               else                 next_state = RESPOND;
            end
         end
         WAIT: begin
            if (counter == 4'd0) next_state = RESPOND;
         end
         RESPOND: begin
            if (resp_ready) next_state = IDLE;
         end
         default: next_state = IDLE;
      endcase
   end

   // Handshake outputs follow directly from the state.
   always_comb begin
      req_ready  = 1'b0;
      resp_valid = 1'b0;
      case (state)
         IDLE:    req_ready  = 1'b1;
         RESPOND: resp_valid = 1'b1;
         default: ;
      endcase
   end

   // Request capture, wait counter and registered response payload.
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         counter     <= 4'd0;
         cap_write   <= 1'b0;
         cap_address <= '0;
         cap_data    <= '0;
`ifdef MEMORY_RESPONDER_BYTE_MASK_EN
         cap_mask    <= '0;
`endif
         resp_data   <= '0;
         resp_error  <= 1'b0;
      end else begin
         if (accept) begin
            counter     <= WAIT_INIT;
            cap_write   <= req_write;
            cap_address <= req_address;
            cap_data    <= req_data;
`ifdef MEMORY_RESPONDER_BYTE_MASK_EN
            cap_mask    <= req_byte_mask;
`endif
         end else if ((state == WAIT) && (counter != 4'd0)) begin
            counter <= counter - 4'd1;
         end
         if (enter_respond) begin
            resp_data  <= (cur_write || request_error) ? '0 : read_data;
            resp_error <= request_error;
         end
      end
   end

endmodule
